// File: rtl/xf100_exu_wbck.sv
// Writeback arbiter: buffers ALU results in a FIFO, arbitrates ALU vs LSU onto a registered regfile write port.
// Latency: LSU grant->write 1 cycle, ALU push->write 2 cycles minimum; ALU is backpressured only by FIFO-full.
module xf100_exu_wbck #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_wbck_valid,
    output logic                          alu_wbck_ready,
    input  logic                          alu_wbck_en,
    input  logic [XLEN-1:0]               alu_wbck_data,
    input  logic [RFIDX_W-1:0]            alu_wbck_rdidx,
    input  logic                          lsu_wbck_valid,
    output logic                          lsu_wbck_ready,
    input  logic                          lsu_wbck_err,
    input  logic [XLEN-1:0]               lsu_wbck_data,
    input  logic [RFIDX_W-1:0]            lsu_wbck_rdidx,
    output logic                          rf_wen,
    output logic [RFIDX_W-1:0]            rf_widx,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          wbck_err,
    output logic [$clog2(FIFO_DEPTH):0]   alu_fifo_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [XLEN-1:0]    mem_dat [FIFO_DEPTH];
    logic [RFIDX_W-1:0] mem_idx [FIFO_DEPTH];

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               rf_wen_q, rf_wen_d, err_q, err_d;
    logic [RFIDX_W-1:0] rf_widx_q, rf_widx_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

    logic full, a_cand, a_win, l_win, store;

    assign full           = (cnt_q == CW'(FIFO_DEPTH));
    assign alu_wbck_ready = !full;
    // Results that would never write the regfile complete the handshake but take no slot.
    assign store          = alu_wbck_valid && !full && alu_wbck_en && (alu_wbck_rdidx != '0);

    assign a_cand         = (cnt_q != '0);
    assign a_win          = a_cand && (!lsu_wbck_valid || (starve_q == SW'(STARVE_MAX)));
    assign l_win          = lsu_wbck_valid && !a_win;
    assign lsu_wbck_ready = l_win;

    always_comb begin
        wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = a_win ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (store && !a_win)
            cnt_d = cnt_q + CW'(1);
        else if (!store && a_win)
            cnt_d = cnt_q - CW'(1);

        starve_d = starve_q;
        if (!a_cand || a_win)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);

        rf_wen_d   = 1'b0;
        err_d      = 1'b0;
        rf_widx_d  = rf_widx_q;
        rf_wdata_d = rf_wdata_q;
        if (a_win) begin
            rf_wen_d   = 1'b1;
            rf_widx_d  = mem_idx[rd_ptr_q];
            rf_wdata_d = mem_dat[rd_ptr_q];
        end else if (l_win) begin
            rf_wen_d   = !lsu_wbck_err && (lsu_wbck_rdidx != '0);
            err_d      = lsu_wbck_err;
            rf_widx_d  = lsu_wbck_rdidx;
            rf_wdata_d = lsu_wbck_data;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_dat[wr_ptr_q] <= alu_wbck_data;
            mem_idx[wr_ptr_q] <= alu_wbck_rdidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            rf_wen_q   <= 1'b0;
            err_q      <= 1'b0;
            rf_widx_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            rf_wen_q   <= rf_wen_d;
            err_q      <= err_d;
            rf_widx_q  <= rf_widx_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_widx      = rf_widx_q;
    assign rf_wdata     = rf_wdata_q;
    assign wbck_err     = err_q;
    assign alu_fifo_cnt = cnt_q;

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// Bench for xf100_exu_wbck: directed scenarios plus random traffic against a queue-based reference model.
module tb_xf100_exu_wbck;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wbck_valid, alu_wbck_ready, alu_wbck_en;
    logic [31:0] alu_wbck_data;
    logic [4:0]  alu_wbck_rdidx;
    logic        lsu_wbck_valid, lsu_wbck_ready, lsu_wbck_err;
    logic [31:0] lsu_wbck_data;
    logic [4:0]  lsu_wbck_rdidx;
    logic        rf_wen, wbck_err;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic [1:0]  alu_fifo_cnt;

    xf100_exu_wbck #(.XLEN(32), .RFIDX_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
        .alu_wbck_en(alu_wbck_en), .alu_wbck_data(alu_wbck_data), .alu_wbck_rdidx(alu_wbck_rdidx),
        .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
        .lsu_wbck_err(lsu_wbck_err), .lsu_wbck_data(lsu_wbck_data), .lsu_wbck_rdidx(lsu_wbck_rdidx),
        .rf_wen(rf_wen), .rf_widx(rf_widx), .rf_wdata(rf_wdata), .wbck_err(wbck_err),
        .alu_fifo_cnt(alu_fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_starve = 0;
    bit          m_valid  = 0;
    logic        e_wen = 0, e_err = 0;
    logic [4:0]  e_idx  = '0;
    logic [31:0] e_data = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare DUT with the model, then advance the model across the edge.
    task automatic step(input logic r, input logic av, input logic aen, input logic [31:0] ad,
                        input logic [4:0] ai, input logic lv, input logic le,
                        input logic [31:0] ld, input logic [4:0] li);
        bit a_present, a_wins, has_room;
        @(negedge clk);
        rst = r;
        alu_wbck_valid = av; alu_wbck_en = aen; alu_wbck_data = ad; alu_wbck_rdidx = ai;
        lsu_wbck_valid = lv; lsu_wbck_err = le; lsu_wbck_data = ld; lsu_wbck_rdidx = li;
        #1;
        a_present = (mq.size() > 0);
        a_wins    = a_present && (!lv || m_starve == SMAX);
        has_room  = (mq.size() < DEPTH);
        if (m_valid) begin
            chk("cnt", alu_fifo_cnt, mq.size());
            chk("alu_ready", alu_wbck_ready, has_room);
            chk("lsu_ready", lsu_wbck_ready, lv && !a_wins);
            chk("rf_wen", rf_wen, e_wen);
            chk("rf_widx", rf_widx, e_idx);
            chk("rf_wdata", rf_wdata, e_data);
            chk("wbck_err", wbck_err, e_err);
        end
        if (r) begin
            mq.delete();
            m_starve = 0;
            e_wen = 0; e_err = 0; e_idx = '0; e_data = '0;
            m_valid = 1;
        end else begin
            if (a_wins) begin
                e_wen = 1; e_err = 0; e_idx = mq[0].idx; e_data = mq[0].data;
                void'(mq.pop_front());
            end else if (lv) begin
                e_wen = !le && (li != 0); e_err = le; e_idx = li; e_data = ld;
            end else begin
                e_wen = 0; e_err = 0;
            end
            if (!a_present || a_wins) m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
            if (av && has_room && aen && ai != 0) mq.push_back('{idx: ai, data: ad});
        end
    endtask

    task automatic idle(input logic r);
        step(r, 0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0);
    endtask

    task automatic do_reset();
        idle(1); idle(1); idle(0);
    endtask

    initial begin
        rst = 1'b1;
        alu_wbck_valid = 0; alu_wbck_en = 0; alu_wbck_data = '0; alu_wbck_rdidx = '0;
        lsu_wbck_valid = 0; lsu_wbck_err = 0; lsu_wbck_data = '0; lsu_wbck_rdidx = '0;

        // Reset state
        do_reset();
        chk("rst_cnt", alu_fifo_cnt, 0);
        chk("rst_wen", rf_wen, 0);
        chk("rst_wdata", rf_wdata, 0);

        // Single ALU push appears two cycles later
        step(0, 1, 1, 32'h1234, 5'd5, 0, 0, 32'h0, 5'd0);
        idle(0);
        chk("t1_cnt_c1", alu_fifo_cnt, 1);
        idle(0);
        chk("t1_wen", rf_wen, 1);
        chk("t1_widx", rf_widx, 5);
        chk("t1_wdata", rf_wdata, 32'h1234);
        chk("t1_cnt_c2", alu_fifo_cnt, 0);

        // Starvation bound under continuous LSU traffic
        do_reset();
        step(0, 1, 1, 32'hA1A1, 5'd9, 1, 0, 32'h100, 5'd3);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 32'h0, 5'd0, 1, 0, 32'h100 + k, 5'd3);
            chk("t2_lsu_ready", lsu_wbck_ready, (k != 5));
        end
        chk("t2_alu_wdata", rf_wdata, 32'hA1A1);
        chk("t2_alu_widx", rf_widx, 9);

        // Three back-to-back pushes with LSU idle drain in order
        do_reset();
        step(0, 1, 1, 32'hD1, 5'd1, 0, 0, 32'h0, 5'd0);
        step(0, 1, 1, 32'hD2, 5'd2, 0, 0, 32'h0, 5'd0);
        step(0, 1, 1, 32'hD3, 5'd3, 0, 0, 32'h0, 5'd0);
        chk("t3_w0", rf_wdata, 32'hD1);
        idle(0);
        chk("t3_w1", rf_wdata, 32'hD2);
        idle(0);
        chk("t3_w2", rf_wdata, 32'hD3);

        // Non-writing ALU results are accepted but not stored
        do_reset();
        step(0, 1, 1, 32'h55, 5'd0, 0, 0, 32'h0, 5'd0);
        chk("t4_rdy_a", alu_wbck_ready, 1);
        step(0, 1, 0, 32'h66, 5'd6, 0, 0, 32'h0, 5'd0);
        idle(0);
        chk("t4_cnt", alu_fifo_cnt, 0);
        idle(0);
        chk("t4_wen", rf_wen, 0);

        // LSU fault retires with an error pulse and no write
        step(0, 0, 0, 32'h0, 5'd0, 1, 1, 32'hBAD, 5'd7);
        chk("t5_lsu_ready", lsu_wbck_ready, 1);
        idle(0);
        chk("t5_err", wbck_err, 1);
        chk("t5_wen", rf_wen, 0);
        chk("t5_widx", rf_widx, 7);
        idle(0);
        chk("t5_err_pulse", wbck_err, 0);

        // Reset with FIFO full and an LSU grant pending
        do_reset();
        step(0, 1, 1, 32'hE1, 5'd4, 1, 0, 32'h10, 5'd8);
        step(0, 1, 1, 32'hE2, 5'd4, 1, 0, 32'h11, 5'd8);
        step(0, 1, 1, 32'hE3, 5'd4, 1, 0, 32'h12, 5'd8);
        chk("t6_full_rdy", alu_wbck_ready, 0);
        chk("t6_full_cnt", alu_fifo_cnt, 2);
        step(1, 0, 0, 32'h0, 5'd0, 1, 0, 32'h13, 5'd8);
        idle(0);
        chk("t6_cnt", alu_fifo_cnt, 0);
        chk("t6_wen", rf_wen, 0);
        chk("t6_err", wbck_err, 0);
        chk("t6_rdy", alu_wbck_ready, 1);

        // Random traffic with varying LSU pressure and occasional reset
        begin
            int lp;
            lp = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) lp = (c / 200) % 3 == 0 ? 95 : ((c / 200) % 3 == 1 ? 50 : 5);
                step($urandom_range(0, 149) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) != 0,
                     $urandom,
                     $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31)),
                     $urandom_range(0, 99) < lp,
                     $urandom_range(0, 7) == 0,
                     $urandom,
                     5'($urandom_range(0, 31)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
